// File: rtl/pipe_param_shift_rotator.sv
// Pipelined barrel shift/rotate unit. Each amount bit has its own stage, the
// whole pipe stalls as one on output back-pressure, and both sides use val/rdy.

// One stage of the shifter: moves the data by SHIFT positions when i_en is set.
module pprs_stage #(
  parameter int NBITS = 8,
  parameter int SHIFT = 1
) (
  input  logic [NBITS-1:0] i_data,
  input  logic             i_en,
  input  logic [1:0]       i_op,
  output logic [NBITS-1:0] o_data
);
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        2'd0:    o_data = (i_data << SHIFT) | (i_data >> (NBITS - SHIFT));
        2'd1:    o_data = (i_data >> SHIFT) | (i_data << (NBITS - SHIFT));
        2'd2:    o_data = i_data << SHIFT;
        // The incoming MSB is still the operand's sign, so the cascade stays arithmetic.
        default: o_data = $unsigned($signed(i_data) >>> SHIFT);
      endcase
    end
  end
endmodule

module pipe_param_shift_rotator #(
  parameter int nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [nbits-1:0]         in_,
  input  logic [$clog2(nbits)-1:0] amt,
  input  logic [1:0]               op,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [nbits-1:0]         out
);
  localparam int NSTAGES = $clog2(nbits);

  // Index NSTAGES is the output register that follows the last shift stage.
  logic [NSTAGES:0]                r_vld_pipe;
  logic [NSTAGES:0][nbits-1:0]     r_data;
  logic [NSTAGES-1:0][1:0]         r_op;
  logic [NSTAGES-1:0][nbits-1:0]   w_shf;
  logic                            w_adv;

  assign w_adv   = !r_vld_pipe[NSTAGES] || out_rdy;
  assign in_rdy  = w_adv && !reset;
  assign out_val = r_vld_pipe[NSTAGES];
  assign out     = r_data[NSTAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
      r_op       <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[NSTAGES-1:0], in_val};
      r_data[0]  <= in_;
      r_op[0]    <= op;
      for (int k = 1; k <= NSTAGES; k++) r_data[k] <= w_shf[k-1];
      for (int k = 1; k < NSTAGES; k++)  r_op[k]   <= r_op[k-1];
    end
  end

  // Stage k keeps only the amount bits it and later stages still need; bit 0 is its own.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_st
    logic [NSTAGES-1-k:0] r_amt;

    pprs_stage #(.NBITS(nbits), .SHIFT(1 << k)) u_stage (
      .i_data (r_data[k]),
      .i_en   (r_amt[0]),
      .i_op   (r_op[k]),
      .o_data (w_shf[k])
    );

    if (k == 0) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_amt <= '0;
        else if (w_adv) r_amt <= amt;
      end
    end else begin : g_body
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_amt <= '0;
        else if (w_adv) r_amt <= g_st[k-1].r_amt[NSTAGES-k:1];
      end
    end
  end
endmodule

// File: tb/tb_pipe_param_shift_rotator.sv
// Bench for pipe_param_shift_rotator at widths 4, 8 and 16; one instance is
// active at a time and a shared scoreboard queue checks results in order.
module tb_pipe_param_shift_rotator;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_v, o_rdy;
  logic [15:0] din;
  logic [3:0]  amt;
  logic [1:0]  op;
  int          cur;

  logic        iv4, iv8, iv16, rdy4, rdy8, rdy16, ov4, ov8, ov16;
  logic [3:0]  o4;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [15:0] m_out;
  logic        m_ov, m_rdy;

  always #5 clk = ~clk;

  assign iv4  = in_v && (cur == 0);
  assign iv8  = in_v && (cur == 1);
  assign iv16 = in_v && (cur == 2);

  pipe_param_shift_rotator #(.nbits(4)) u4 (
    .clk(clk), .reset(reset), .in_val(iv4), .in_rdy(rdy4), .in_(din[3:0]),
    .amt(amt[1:0]), .op(op), .out_val(ov4), .out_rdy(o_rdy), .out(o4));
  pipe_param_shift_rotator #(.nbits(8)) u8 (
    .clk(clk), .reset(reset), .in_val(iv8), .in_rdy(rdy8), .in_(din[7:0]),
    .amt(amt[2:0]), .op(op), .out_val(ov8), .out_rdy(o_rdy), .out(o8));
  pipe_param_shift_rotator #(.nbits(16)) u16 (
    .clk(clk), .reset(reset), .in_val(iv16), .in_rdy(rdy16), .in_(din),
    .amt(amt), .op(op), .out_val(ov16), .out_rdy(o_rdy), .out(o16));

  always_comb begin
    m_out = 16'h0; m_ov = 1'b0; m_rdy = 1'b0;
    case (cur)
      0:       begin m_out = {12'h0, o4}; m_ov = ov4;  m_rdy = rdy4;  end
      1:       begin m_out = {8'h0, o8};  m_ov = ov8;  m_rdy = rdy8;  end
      default: begin m_out = o16;         m_ov = ov16; m_rdy = rdy16; end
    endcase
  end

  int          n_vec = 0, n_err = 0, cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] next_exp;
  logic        got_in, got_out;
  int          first_oc, last_oc, n_oc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cyc %0d, width idx %0d)", nm, act, exp, cyc, cur);
    end
  endtask

  // Reference result, computed directly from the full operand and amount.
  function automatic logic [15:0] model(input logic [15:0] d, input int a,
                                        input logic [1:0] o, input int nb);
    logic [15:0] m, r, x;
    m = (nb == 16) ? 16'hFFFF : ((16'h1 << nb) - 16'h1);
    x = d & m;
    case (o)
      2'd0:    r = ((x << a) | (x >> (nb - a))) & m;
      2'd1:    r = ((x >> a) | (x << (nb - a))) & m;
      2'd2:    r = (x << a) & m;
      default: begin
        r = x >> a;
        if (x[nb-1]) r = r | (m & ~(m >> a));
      end
    endcase
    return r;
  endfunction

  // One clock: observe transfers at the falling edge, then move past the rising edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    got_in  = in_v && m_rdy;
    got_out = m_ov && o_rdy;
    if (got_in) exp_q.push_back(next_exp);
    if (got_out) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_out: got %h, expected no output", m_out);
      end else begin
        e = exp_q.pop_front();
        chk("result", {16'h0, m_out}, {16'h0, e});
      end
      if (first_oc < 0) first_oc = cyc;
      last_oc = cyc;
      n_oc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string nm);
    int g;
    in_v = 1'b0; o_rdy = 1'b1; g = 0;
    while (exp_q.size() != 0 && g < 60) begin step(); g++; end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    int          w;
    logic [15:0] d;
    logic [3:0]  a;
    logic [1:0]  o;
    logic [15:0] e;
  } vec_t;
  vec_t tv[$];

  initial begin
    logic [15:0] snap;
    int cnt, nacc, g, nb;

    tv.push_back('{0, 16'hD, 4'd1, 2'd0, 16'hB});
    tv.push_back('{0, 16'hD, 4'd1, 2'd1, 16'hE});
    tv.push_back('{0, 16'hD, 4'd1, 2'd2, 16'hA});
    tv.push_back('{0, 16'hD, 4'd1, 2'd3, 16'hE});
    tv.push_back('{1, 16'h5D, 4'd3, 2'd0, 16'hEA});
    tv.push_back('{1, 16'hD5, 4'd3, 2'd1, 16'hBA});
    tv.push_back('{1, 16'hD5, 4'd7, 2'd3, 16'hFF});
    tv.push_back('{1, 16'hD5, 4'd7, 2'd2, 16'h80});
    tv.push_back('{1, 16'h9D, 4'd0, 2'd0, 16'h9D});
    tv.push_back('{1, 16'h9D, 4'd0, 2'd1, 16'h9D});
    tv.push_back('{1, 16'h9D, 4'd0, 2'd2, 16'h9D});
    tv.push_back('{1, 16'h9D, 4'd0, 2'd3, 16'h9D});
    tv.push_back('{2, 16'h8001, 4'd15, 2'd3, 16'hFFFF});
    tv.push_back('{2, 16'h7FFF, 4'd15, 2'd3, 16'h0000});
    tv.push_back('{2, 16'h8001, 4'd1, 2'd0, 16'h0003});
    tv.push_back('{2, 16'h1234, 4'd4, 2'd1, 16'h4123});
    tv.push_back('{2, 16'h00F1, 4'd15, 2'd2, 16'h8000});

    reset = 1'b1; in_v = 1'b0; o_rdy = 1'b1; din = '0; amt = '0; op = '0;
    cur = 0; next_exp = '0; first_oc = -1; last_oc = 0; n_oc = 0;
    @(posedge clk); #1;
    for (int w = 0; w < 3; w++) begin
      cur = w; #1;
      chk("rst_out_val", m_ov, 0);
      chk("rst_in_rdy", m_rdy, 0);
      chk("rst_out", m_out, 0);
    end
    cur = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("in_rdy_after_rst", m_rdy, 1);

    // Directed table: result via the scoreboard, plus exact latency per width.
    foreach (tv[i]) begin
      cur = tv[i].w; din = tv[i].d; amt = tv[i].a; op = tv[i].o;
      next_exp = tv[i].e; in_v = 1'b1; o_rdy = 1'b1;
      step();
      chk("accept", got_in, 1);
      in_v = 1'b0; cnt = 0;
      do begin step(); cnt++; end while (!got_out && cnt < 20);
      chk("latency", cnt - 1, tv[i].w + 2);
    end
    drain("table_drain");

    // Back-to-back stream at width 8: eight results on consecutive cycles.
    cur = 1; o_rdy = 1'b1; first_oc = -1; n_oc = 0;
    for (int a = 0; a < 8; a++) begin
      din = 16'h96; amt = 4'(a); op = 2'd0; next_exp = model(din, a, op, 8); in_v = 1'b1;
      step();
      chk("b2b_in_rdy", got_in, 1);
    end
    drain("b2b_drain");
    chk("b2b_count", n_oc, 8);
    chk("b2b_consecutive", last_oc - first_oc, 7);

    // Back-pressure: fill the pipe, stall five cycles, then drain in order.
    cur = 1; o_rdy = 1'b1; n_oc = 0;
    for (int a = 0; a < 4; a++) begin
      din = 16'(16'h31 * (a + 1)); amt = 4'(a + 2); op = 2'(a);
      next_exp = model(din, a + 2, op, 8); in_v = 1'b1;
      step();
    end
    din = 16'hC3; amt = 4'd5; op = 2'd3; next_exp = model(din, 5, op, 8);
    o_rdy = 1'b0; #1;
    snap = m_out;
    chk("bp_out_val", m_ov, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_in_rdy", m_rdy, 0);
      chk("bp_hold_val", m_ov, 1);
      chk("bp_hold_out", m_out, snap);
    end
    o_rdy = 1'b1;
    step();
    chk("bp_late_accept", got_in, 1);
    drain("bp_drain");
    chk("bp_count", n_oc, 5);

    // Reset mid-flight at width 4: in-flight work is discarded.
    cur = 0; o_rdy = 1'b1;
    for (int a = 0; a < 2; a++) begin
      din = 16'h9; amt = 4'(a + 1); op = 2'd0; next_exp = model(din, a + 1, op, 4); in_v = 1'b1;
      step();
    end
    in_v = 1'b0; o_rdy = 1'b0;
    step();
    chk("pre_rst_val", m_ov, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_val", m_ov, 0);
    chk("async_rst_out", m_out, 0);
    exp_q.delete();
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    o_rdy = 1'b1; n_oc = 0;
    for (int c = 0; c < 8; c++) step();
    chk("no_stale", n_oc, 0);
    din = 16'hB; amt = 4'd3; op = 2'd3; next_exp = model(din, 3, op, 4); in_v = 1'b1;
    step();
    chk("post_rst_accept", got_in, 1);
    drain("post_rst_drain");
    chk("post_rst_count", n_oc, 1);

    // Random traffic with random valid/ready on each width.
    for (int w = 0; w < 3; w++) begin
      cur = w; nb = 4 << w; nacc = 0; g = 0; in_v = 1'b0;
      while (nacc < 200 && g < 5000) begin
        if (!in_v && $urandom_range(3) != 0) begin
          din = 16'($urandom); amt = 4'($urandom_range(nb - 1)); op = 2'($urandom_range(3));
          next_exp = model(din, int'(amt), op, nb); in_v = 1'b1;
        end
        o_rdy = ($urandom_range(3) != 0);
        step(); g++;
        if (got_in) begin nacc++; in_v = 1'b0; end
      end
      chk("rand_accepted", nacc, 200);
      drain("rand_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
